// File: rtl/priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : priority_arbiter
// Description : Fixed-priority arbiter with a registered one-hot grant.
//               Bit 0 has the highest priority. The grant is re-evaluated
//               every cycle from the current request vector, so no requester
//               holds the resource across cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_arbiter #(
    // Number of requesters, legal range 1..32
    parameter int PORTS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    output logic [PORTS-1:0] gnt
);

    // Next grant: one-hot lowest-index request, or zero when nothing requests
    logic [PORTS-1:0] w_gnt_next;
    // Any request at an index strictly below the current loop position
    logic             w_seen;

    // Registered grant; reset clears it regardless of the request vector
    logic [PORTS-1:0] r_gnt;

    // Priority scan from index 0 upward; the first set request wins and
    // every later bit is masked by the running "already seen" flag
    always_comb begin
        w_gnt_next = '0;
        w_seen     = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (req[i] && !w_seen) begin
                w_gnt_next[i] = 1'b1;
            end
            w_seen = w_seen | req[i];
        end
    end

    // Grant register: no combinational path from req to gnt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt <= '0;
        end else begin
            r_gnt <= w_gnt_next;
        end
    end

    assign gnt = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_arbiter
// Description : Self-checking bench for priority_arbiter (PORTS = 4):
//               directed vector table, a between-edge stability sequence and
//               a random regression with invariant checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_arbiter;

    localparam int c_PORTS = 4;

    logic               clk;
    logic               rst;
    logic [c_PORTS-1:0] req;
    logic [c_PORTS-1:0] gnt;

    int n_vec;
    int n_err;

    typedef struct {
        string              name;
        logic               rst;
        logic [c_PORTS-1:0] req;
        logic [c_PORTS-1:0] exp_gnt;
    } vec_t;

    vec_t vecs[$];

    priority_arbiter #(
        .PORTS (c_PORTS)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [c_PORTS-1:0] act,
                         input logic [c_PORTS-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: gnt=%b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic r,
                                input logic [3:0] q, input logic [3:0] g);
        vec_t v;
        v.name    = n;
        v.rst     = r;
        v.req     = q;
        v.exp_gnt = g;
        return v;
    endfunction

    initial begin
        logic [c_PORTS-1:0] prev_req;
        logic [c_PORTS-1:0] exp;
        logic [c_PORTS-1:0] held;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 4'b1111;

        // Each record: inputs applied before an edge, grant expected after it
        vecs.push_back(mk("reset_1",       1'b1, 4'b1111, 4'b0000));
        vecs.push_back(mk("reset_2",       1'b1, 4'b1111, 4'b0000));
        vecs.push_back(mk("reset_release", 1'b0, 4'b1111, 4'b0001));
        vecs.push_back(mk("single_0",      1'b0, 4'b0001, 4'b0001));
        vecs.push_back(mk("single_1",      1'b0, 4'b0010, 4'b0010));
        vecs.push_back(mk("single_2",      1'b0, 4'b0100, 4'b0100));
        vecs.push_back(mk("single_3",      1'b0, 4'b1000, 4'b1000));
        vecs.push_back(mk("single_none",   1'b0, 4'b0000, 4'b0000));
        vecs.push_back(mk("prio_1010",     1'b0, 4'b1010, 4'b0010));
        vecs.push_back(mk("prio_1100",     1'b0, 4'b1100, 4'b0100));
        vecs.push_back(mk("prio_1111",     1'b0, 4'b1111, 4'b0001));
        vecs.push_back(mk("prio_1000",     1'b0, 4'b1000, 4'b1000));
        vecs.push_back(mk("starve_hold3",  1'b0, 4'b1000, 4'b1000));
        vecs.push_back(mk("preempt_0",     1'b0, 4'b1001, 4'b0001));
        vecs.push_back(mk("starve_a",      1'b0, 4'b1001, 4'b0001));
        vecs.push_back(mk("starve_b",      1'b0, 4'b1001, 4'b0001));
        vecs.push_back(mk("drop_0",        1'b0, 4'b1000, 4'b1000));
        vecs.push_back(mk("mid_setup",     1'b0, 4'b0110, 4'b0010));
        vecs.push_back(mk("mid_rst",       1'b1, 4'b0110, 4'b0000));
        vecs.push_back(mk("mid_resume",    1'b0, 4'b0110, 4'b0010));
        vecs.push_back(mk("mid_steady",    1'b0, 4'b0110, 4'b0010));

        // Table-driven directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            @(posedge clk);
            #1;
            check(vecs[i].name, gnt, vecs[i].exp_gnt);
        end

        // A req change between edges must not reach gnt until the next edge
        req = 4'b0100;
        @(posedge clk);
        #1;
        check("stable_setup", gnt, 4'b0100);
        #2;
        req = 4'b0001;
        #3;
        check("stable_between_edges", gnt, 4'b0100);
        @(posedge clk);
        #1;
        check("stable_next_edge", gnt, 4'b0001);

        // Random regression with scoreboard and invariants
        prev_req = req;
        for (int i = 0; i < 1000; i++) begin
            req = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            held     = req;
            // Lowest set bit via two's complement isolation
            exp      = held & (~held + 4'd1);
            check("rand_scoreboard", gnt, exp);
            check("rand_onehot", gnt & (gnt - 4'd1), 4'b0000);
            check("rand_subset", gnt & ~held, 4'b0000);
            prev_req = held;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_arbiter.md
# priority_arbiter

Fixed-priority arbiter granting one of `PORTS` requesters per clock cycle, with a registered one-hot grant. Bit 0 has the highest priority and bit `PORTS-1` the lowest. It sits in front of a shared resource, such as a bus, memory port or FIFO write port, where simple static priority is enough and fairness is not required. The block does not store which requester was granted between cycles.

## Interface
Parameters:
- `PORTS`, default 4: number of requesters. The legal range is 1 to 32.

Ports:
- `clk`, input, 1 bit: the single clock. All state updates on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`, input, `PORTS` bits: request vector. Bit *i* high means requester *i* wants the resource in this cycle.
- `gnt`, output, `PORTS` bits: registered grant vector. At most one bit is high; bit *i* high grants requester *i*.

## Operation
- **Combinational next grant.**
  - `gnt_next` has exactly one bit set: the lowest-index set bit of `req`.
  - If `req == 0`, then `gnt_next = 0`.
  - The reference formulation is `gnt_next = req & (~req + 1)`, evaluated at `PORTS` bits with wrap-around discarded. A priority-encoder loop is equally acceptable.
- **Register.** On each rising edge of `clk`:
  - if `rst` is high, `gnt <= 0`;
  - otherwise, `gnt <= gnt_next`.
- **Fixed priority.** Priority never rotates. A continuously asserted `req[0]` starves all other requesters; this is intended behaviour.
- **No lock or hold.**
  - The grant is re-evaluated every cycle from the current `req`.
  - A granted requester loses its grant in the cycle after a higher-priority request appears, or after its own request drops.
- **Invariants.** These hold in every cycle, including during reset:
  - `gnt` is one-hot or zero: `(gnt & (gnt - 1)) == 0`.
  - `gnt` is a subset of the `req` vector from the previous cycle.
- **Unknown inputs.** The block is not required to handle X or Z on `req`. Verification drives only known values.
- **Degenerate width.** With `PORTS = 1`, the block reduces to `gnt <= req` (registered, reset to 0).

## Timing
- **Latency.** The grant appears one cycle after the request: `req` sampled at edge *n* produces `gnt` valid after edge *n*. `gnt` changes only at the rising edge of `clk`.
- **Reset value.** `gnt = 0` after any edge where `rst` is high.
  - `req` is ignored during those edges.
  - The first grant appears after the first edge with `rst` low.
- **Reset mid-operation.** Asserting `rst` while a grant is active clears `gnt` at the next edge, with no partial state. Deasserting `rst` resumes normal arbitration on the following edge.
- **Simultaneous events.**
  - When several bits of `req` are set in the same cycle, only the lowest index is granted.
  - A `req` change between edges has no effect on `gnt` until the next edge.
- **No glitches.** There is no combinational path from `req` to `gnt`.

## Test plan
All scenarios use `PORTS = 4`.

1. **Reset.** Hold `rst = 1` for 2 cycles with `req = 4'b1111`. Required: `gnt = 4'b0000` during and immediately after reset. Then deassert `rst`. Required: after the next edge, `gnt = 4'b0001`.
2. **Single requesters.** Drive `req` through `4'b0001`, `0010`, `0100`, `1000`, `0000`. Required: one cycle later, `gnt` equals each value in turn, ending at `4'b0000`.
3. **Priority resolution.**
   - `req = 4'b1010` gives `gnt = 4'b0010`.
   - `req = 4'b1100` gives `gnt = 4'b0100`.
   - `req = 4'b1111` gives `gnt = 4'b0001`.
   - `req = 4'b1000` gives `gnt = 4'b1000`.
4. **Preemption and starvation.**
   - Hold `req[3] = 1`. After one cycle, `gnt = 4'b1000`.
   - Raise `req[0]`. After the next edge, `gnt = 4'b0001`, and it stays there while `req[0]` is held.
   - Drop `req[0]`. After the next edge, `gnt = 4'b1000`.
5. **Mid-operation reset.** With `req = 4'b0110` and `gnt = 4'b0010`, pulse `rst` for 1 cycle. Required: `gnt = 4'b0000` for exactly that cycle, then `4'b0010` again.
6. **Random regression.**
   - Apply at least 32 random `req` values in the range 0 to 15 (at least 1000 recommended), one per cycle.
   - Scoreboard each `gnt` against the lowest set bit of the previous cycle's `req`.
   - Assert the one-hot-or-zero and subset invariants every cycle.
